// File: rtl/iir_channel_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iir_channel_scheduler: round-robin TDM front end for a shared IIR datapath
// Rev 1.0
// ---------------------------------------------------------------------------
module iir_channel_scheduler #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int LATENCY = 1,
  localparam int CHW    = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     flt_x,
  output logic              flt_valid,
  output logic [CHW-1:0]    flt_ch,
  output logic              flt_clr,
  input  logic [DW-1:0]     flt_y,
  output logic [DW-1:0]     out_y,
  output logic [CHW-1:0]    out_ch,
  output logic              out_valid,
  output logic              idle
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_clear = 2'd1;
  localparam logic [1:0] c_run   = 2'd2;
  localparam logic [1:0] c_drain = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]  flt_x_q, flt_x_d;
  logic [CHW-1:0] flt_ch_q, flt_ch_d;
  logic           flt_valid_q, flt_valid_d;
  logic           flt_clr_q, flt_clr_d;
  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [CHW-1:0] tag_ch_q [LATENCY];
  logic [CHW-1:0] tag_ch_d [LATENCY];
  logic [DW-1:0]  out_y_q, out_y_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic           out_valid_q, out_valid_d;

  logic           grant_found;
  logic [CHW-1:0] grant_idx;
  logic [CHW-1:0] cand;
  logic           handshake;
  logic           pipe_busy;

  // The issue register is the first of the LATENCY+1 in-flight stages.
  assign pipe_busy = flt_valid_q | (|tag_v_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (en) state_d = c_clear;
      c_clear: state_d = c_run;
      c_run:   if (!en) state_d = c_drain;
      c_drain: if (!pipe_busy) state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = '0;
    if ((state_q == c_run) && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
    idle      = (state_q == c_idle) && !pipe_busy;
    flt_clr_d = (state_d == c_clear);
  end

  // Wrap-around search starting one past the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = ptr_q + CHW'(k);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign handshake = |in_ready;

  always_comb begin
    ptr_d       = handshake ? grant_idx : ptr_q;
    flt_valid_d = handshake;
    flt_x_d     = handshake ? in_data[grant_idx*DW +: DW] : flt_x_q;
    flt_ch_d    = handshake ? grant_idx : flt_ch_q;

    tag_v_d[0]  = flt_valid_q;
    tag_ch_d[0] = flt_ch_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_ch_d[i] = tag_ch_q[i-1];
    end

    out_valid_d = tag_v_q[LATENCY-1];
    out_y_d     = tag_v_q[LATENCY-1] ? flt_y : out_y_q;
    out_ch_d    = tag_v_q[LATENCY-1] ? tag_ch_q[LATENCY-1] : out_ch_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= CHW'(NCH - 1);
      flt_x_q     <= '0;
      flt_ch_q    <= '0;
      flt_valid_q <= 1'b0;
      flt_clr_q   <= 1'b0;
      tag_v_q     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_ch_q[i] <= '0;
      end
      out_y_q     <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      flt_x_q     <= flt_x_d;
      flt_ch_q    <= flt_ch_d;
      flt_valid_q <= flt_valid_d;
      flt_clr_q   <= flt_clr_d;
      tag_v_q     <= tag_v_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_ch_q[i] <= tag_ch_d[i];
      end
      out_y_q     <= out_y_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign flt_x     = flt_x_q;
  assign flt_ch    = flt_ch_q;
  assign flt_valid = flt_valid_q;
  assign flt_clr   = flt_clr_q;
  assign out_y     = out_y_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_channel_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_iir_channel_scheduler: directed bench with a one-cycle pass-through filter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_iir_channel_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0]    in_ready;
  logic [DW-1:0]     flt_x;
  logic              flt_valid;
  logic [1:0]        flt_ch;
  logic              flt_clr;
  logic [DW-1:0]     flt_y = '0;
  logic [DW-1:0]     out_y;
  logic [1:0]        out_ch;
  logic              out_valid;
  logic              idle;

  int n_checks = 0;
  int n_pass   = 0;

  iir_channel_scheduler #(.NCH(NCH), .DW(DW), .LATENCY(1)) dut (
    .clk(clk), .reset(rst_n), .en(en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flt_x(flt_x), .flt_valid(flt_valid), .flt_ch(flt_ch), .flt_clr(flt_clr),
    .flt_y(flt_y),
    .out_y(out_y), .out_ch(out_ch), .out_valid(out_valid), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) flt_y <= flt_x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    in_data = {16'd40, 16'd30, 16'd20, 16'd100};
    repeat (2) @(posedge clk);
    #1;
    check("rst_idle", idle, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_flt_valid", flt_valid, 0);
    check("rst_flt_clr", flt_clr, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    step;
    check("idle_before_en", idle, 1);

    en = 1'b1;
    in_valid = 4'b0001;
    step;
    check("clr_pulse", flt_clr, 1);
    check("clr_in_ready", in_ready, 0);
    step;
    check("clr_done", flt_clr, 0);
    check("run_in_ready", in_ready, 4'b0001);
    step;
    in_valid = 4'b0000;
    check("issue_valid", flt_valid, 1);
    check("issue_x", flt_x, 100);
    check("issue_ch", flt_ch, 0);
    check("issue_out_early", out_valid, 0);
    step;
    check("issue_off", flt_valid, 0);
    check("out_not_yet", out_valid, 0);
    step;
    check("out_valid", out_valid, 1);
    check("out_y", out_y, 100);
    check("out_ch", out_ch, 0);
    step;
    check("out_one_cycle", out_valid, 0);

    in_data = {16'd40, 16'd30, 16'd20, 16'd10};
    in_valid = 4'b0100;
    #1 check("ptr_grant2", in_ready, 4'b0100);
    step;
    check("ptr_ch2", flt_ch, 2);
    check("ptr_x2", flt_x, 30);
    in_valid = 4'b1010;
    #1 check("ptr_grant3", in_ready, 4'b1000);
    step;
    check("ptr_ch3", flt_ch, 3);
    in_valid = 4'b0010;
    #1 check("ptr_grant1", in_ready, 4'b0010);
    step;
    in_valid = 4'b0000;
    check("ptr_ch1", flt_ch, 1);
    check("ptr_x1", flt_x, 20);
    check("ptr_out0_v", out_valid, 1);
    check("ptr_out0_ch", out_ch, 2);
    check("ptr_out0_y", out_y, 30);
    step;
    check("ptr_out1_ch", out_ch, 3);
    check("ptr_out1_y", out_y, 40);
    step;
    check("ptr_out2_v", out_valid, 1);
    check("ptr_out2_ch", out_ch, 1);
    check("ptr_out2_y", out_y, 20);
    step;
    check("ptr_out_end", out_valid, 0);

    in_valid = 4'b0001;
    #1 check("drain_grant0", in_ready, 4'b0001);
    step;
    en = 1'b0;
    #1 check("drain_same_cycle", in_ready, 4'b0001);
    step;
    check("drain_ready_off", in_ready, 0);
    check("drain_last_issue", flt_valid, 1);
    check("drain_last_ch", flt_ch, 0);
    in_valid = 4'b0000;
    step;
    check("drain_out0", out_valid, 1);
    check("drain_out0_y", out_y, 10);
    step;
    check("drain_out1", out_valid, 1);
    check("drain_busy", idle, 0);
    step;
    check("drain_out_end", out_valid, 0);
    check("drain_idle", idle, 1);

    en = 1'b1;
    in_valid = 4'b0001;
    step;
    check("reclr_pulse", flt_clr, 1);
    step;
    check("reclr_done", flt_clr, 0);
    step;
    step;
    check("inflight_valid", flt_valid, 1);
    check("inflight_no_out", out_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_flt_valid", flt_valid, 0);
    check("arst_flt_x", flt_x, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_idle", idle, 1);
    check("arst_out_y", out_y, 0);
    check("arst_out_valid", out_valid, 0);
    in_valid = 4'b0000;
    en = 1'b0;
    step;
    step;
    check("arst_hold_out", out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("arst_no_out", out_valid, 0);
    end

    en = 1'b1;
    step;
    step;
    in_valid = 4'b1111;
    #1 check("rr_first_ch0", in_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      step;
      if (i == 4) in_valid = 4'b0000;
      if (i < 5) begin
        check("rr_flt_ch", flt_ch, i % 4);
        check("rr_flt_x", flt_x, ((i % 4) + 1) * 10);
      end
      if (i == 5) check("rr_issue_stop", flt_valid, 0);
      if (i >= 2 && i < 7) begin
        check("rr_out_v", out_valid, 1);
        check("rr_out_ch", out_ch, (i - 2) % 4);
        check("rr_out_y", out_y, (((i - 2) % 4) + 1) * 10);
      end
      if (i == 7) check("rr_out_end", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
